// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the opcode constants, the 4-bit state encodings, the ALU class codes,
// the mux select codes and the packed control-word struct used between the
// state register and the output decoder.
package mips_pkg;

  // Opcode field values, IR[31:26]
  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] J        = 6'd2;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;
  localparam logic [5:0] HALT     = 6'd63;

  // ALU operation class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source mux
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU B-input mux
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    JUMP_EX  = 4'd9,
    HALTED   = 4'd10,
    ERROR    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halt;
    logic       error;
  } ctrl_t;

endpackage

// File: rtl/control_multi_if.sv
// Controller <-> datapath bundle for control_multi.
// master: the controller (reads opcode/mem_ready, drives strobes, selects,
//         Halt/Error, state and the cycle counter).
// slave:  the datapath/observer side.
// Parameter CNT_W sets the width of the cycle counter.
interface control_multi_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             IRWrite;
  logic             ALUSrcA;
  logic             RegWrite;
  logic             RegDst;
  logic [1:0]       PCSource;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             Halt;
  logic             Error;
  logic [3:0]       state;
  logic [CNT_W-1:0] cycles;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, Halt, Error,
           state, cycles
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, Halt, Error,
           state, cycles
  );
endinterface

// File: rtl/control_multi_outdec.sv
// Combinational output decoder: current state (+ mem_ready for the FETCH
// IR/PC write strobes) -> control word. Every field not set for a state is 0.
// Ports: state (in), mem_ready (in), ctrl (out, ctrl_t).
// Optional feature macro: CONTROL_MULTI_JUMP_EN (decodes JUMP_EX).
module control_multi_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BEQ_EX: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_BRANCH;
      end
`ifdef CONTROL_MULTI_JUMP_EN
      JUMP_EX: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
`endif
      HALTED: ctrl.halt  = 1'b1;
      ERROR:  ctrl.error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_multi.sv
// Multi-cycle MIPS main controller: state register, next-state logic and a
// saturating cycle counter; output decode lives in control_multi_outdec.
// Ports: clk (rising edge), reset (async, active high),
//        bus (control_multi_if.master: opcode/mem_ready in, strobes,
//        selects, Halt, Error, state, cycles out).
// Parameter CNT_W: cycle counter width.
// Optional feature macro: CONTROL_MULTI_JUMP_EN (opcode 2 -> JUMP_EX;
// otherwise opcode 2 traps to ERROR).
module control_multi
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  control_multi_if.master   bus
);

  state_t           state;
  logic [CNT_W-1:0] cycles;
  ctrl_t            ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.opcode)
            LW, SW:   state <= MEMADR;
            R_FORMAT: state <= RTYPE_EX;
            BEQ:      state <= BEQ_EX;
            HALT:     state <= HALTED;
`ifdef CONTROL_MULTI_JUMP_EN
            J:        state <= JUMP_EX;
`endif
            default:  state <= ERROR;
          endcase
        end
        // opcode is re-sampled here; anything but lw/sw traps
        MEMADR: begin
          if (bus.opcode == LW)      state <= MEMRD;
          else if (bus.opcode == SW) state <= MEMWR;
          else                       state <= ERROR;
        end
        MEMRD:    if (bus.mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWR:    if (bus.mem_ready) state <= FETCH;
        RTYPE_EX: state <= RTYPE_WB;
        RTYPE_WB: state <= FETCH;
        BEQ_EX:   state <= FETCH;
        JUMP_EX:  state <= FETCH;
        HALTED:   state <= HALTED;
        ERROR:    state <= ERROR;
        default:  state <= ERROR;
      endcase
    end
  end

  // Counts every clock spent outside HALTED/ERROR; sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else if (state != HALTED && state != ERROR && cycles != '1) begin
      cycles <= cycles + CNT_W'(1);
    end
  end

  control_multi_outdec u_outdec (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.ior_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.memto_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.Halt        = ctrl.halt;
  assign bus.Error       = ctrl.error;
  assign bus.state       = state;
  assign bus.cycles      = cycles;

endmodule

// File: doc/control_multi.md
CONTROL_MULTI -- requirements
Module: control_multi

Interface
REQ-001 Parameter CNT_W, default 32, width of the cycle counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  IR[31:26]; valid from DECODE onward.
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath strobes/selects.
REQ-007 PCSource, ALUSrcB, ALUOp  output  2 each  PC mux, ALU B mux, ALU class.
REQ-008 Halt  output  1  processor halted.
REQ-009 Error  output  1  unimplemented opcode trapped.
REQ-010 state  output  4  current state encoding.
REQ-011 cycles  output  CNT_W  clocks executed since reset.

Function
REQ-012 States SHALL be: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, JUMP_EX, HALTED, ERROR.
REQ-013 Outputs SHALL be a function of state only, except IRWrite/PCWrite in FETCH; any output not listed for a state SHALL be 0, never X.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready; -> DECODE when mem_ready, else hold.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by opcode: 35/43 -> MEMADR, 0 -> RTYPE_EX, 4 -> BEQ_EX, 63 -> HALTED, others -> ERROR.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> MEMRD if opcode 35, MEMWR if 43.
REQ-017 MEMRD: MemRead=1, IorD=1; -> MEMWB when mem_ready, else hold.
REQ-018 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1, held while waiting; -> FETCH when mem_ready.
REQ-020 RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
REQ-021 BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; -> FETCH.
REQ-022 HALTED: Halt=1, all write strobes 0, absorbing until reset; ERROR: Error=1, all write strobes 0, absorbing until reset.
REQ-023 Latency with mem_ready=1: lw 5, sw 4, R-type 4, beq 3, j 3 cycles; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
REQ-024 opcode SHALL be sampled only in DECODE and MEMADR; changes elsewhere have no effect.
REQ-025 cycles SHALL increment every clock while state is not HALTED/ERROR and saturate at all-ones.

Reset
REQ-026 reset SHALL force state=FETCH and cycles=0 asynchronously from any state, including mid-access wait.
REQ-027 First cycle after reset release SHALL be FETCH with MemRead=1, all write strobes per REQ-014.

Configuration
REQ-028 With CONTROL_MULTI_JUMP_EN defined: opcode 2 in DECODE -> JUMP_EX (PCWrite=1, PCSource=10) -> FETCH.
REQ-029 Without CONTROL_MULTI_JUMP_EN: opcode 2 -> ERROR; JUMP_EX unreachable; PCSource never 10.

Structure
REQ-030 Shared package mips_pkg SHALL hold opcode constants (R_FORMAT 0, J 2, BEQ 4, LW 35, SW 43, HALT 63), 4-bit state encodings, ALUOp codes (00 add, 01 sub, 10 funct).
REQ-031 One sub-module control_multi_outdec: combinational state+mem_ready -> output decode; next-state register and counter stay in control_multi.

Verification
REQ-032 Reset, opcode=35, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; RegWrite=1 only in MEMWB.
REQ-033 opcode=43, mem_ready low 3 cycles in MEMWR -> MemWrite high 4 cycles, single return to FETCH, cycles=7.
REQ-034 opcode=0 then 4 -> RTYPE_WB RegDst=1; BEQ_EX PCWriteCond=1, PCSource=01, ALUOp=01.
REQ-035 opcode=63 -> HALTED, Halt=1, cycles frozen 10 clocks; opcode=17 -> ERROR, Error=1.
REQ-036 opcode=2 -> JUMP_EX with PCSource=10 when CONTROL_MULTI_JUMP_EN defined, ERROR when not.
REQ-037 reset pulsed mid-MEMRD wait -> state=FETCH and cycles=0 before next clock edge.
